pr3_spectrum_integrator: RTL and testbench

- Downstream stage of the PR3 spectral core.
- Consumes PR3's per-bin 32-bit power stream, sums 2^AVG_LOG2 consecutive frames per bin in an on-chip accumulator, then streams the averaged frame out over a ready/valid interface toward the readout/packetizer.
- Reduces output data rate by 2^AVG_LOG2 and averages out noise.

---
 rtl/pr3_pkg.sv | 22 ++
 rtl/pr3_spectrum_integrator_if.sv | 25 ++
 rtl/pr3_acc_ram.sv | 24 ++
 rtl/pr3_spectrum_integrator.sv | 181 ++++++++++++++++++
 tb/tb_pr3_spectrum_integrator.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pr3_pkg.sv
// Shared types and helpers for the PR3 spectrum integrator: FSM states,
// default geometry and the truncating-average helper.
package pr3_pkg;

    typedef enum logic [1:0] {
        WAIT_SOP,
        ACCUM,
        DUMP
    } state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_BINS_LOG2 = 11;
    localparam int DEF_AVG_LOG2  = 4;
    // Summing 2^AVG_LOG2 words of WIDTH bits needs AVG_LOG2 extra bits.
    localparam int DEF_ACC_W     = DEF_WIDTH + DEF_AVG_LOG2;
    localparam int DROP_W        = 16;

    function automatic logic [63:0] avg_trunc(input logic [63:0] sum, input int shift);
        return sum >> shift;
    endfunction

endpackage

// File: rtl/pr3_spectrum_integrator_if.sv
// Sink (from PR3) and source (to readout) stream signals of the integrator.
interface pr3_spectrum_integrator_if
    import pr3_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             sink_valid;
    logic             sink_sop;
    logic [WIDTH-1:0] sink_data;
    logic             source_ready;
    logic             source_valid;
    logic             source_sop;
    logic             source_eop;
    logic [WIDTH-1:0] source_data;

    modport master (
        output sink_valid, sink_sop, sink_data, source_ready,
        input  source_valid, source_sop, source_eop, source_data
    );

    modport slave (
        input  sink_valid, sink_sop, sink_data, source_ready,
        output source_valid, source_sop, source_eop, source_data
    );
endinterface

// File: rtl/pr3_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one read port with
// read enable and 1-cycle latency, single clock.
module pr3_acc_ram
    import pr3_pkg::*;
#(
    parameter int ADDR_W = DEF_BINS_LOG2,
    parameter int DATA_W = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // NOTE: the array and read register have no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/pr3_spectrum_integrator.sv
// Sums 2^AVG_LOG2 PR3 power frames per bin, then streams the truncated
// average out over ready/valid; counts discarded frames in dropped.
module pr3_spectrum_integrator
    import pr3_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BINS_LOG2 = DEF_BINS_LOG2,
    parameter int AVG_LOG2  = DEF_AVG_LOG2
) (
    input  logic                  clk20,
    input  logic                  reset,
    pr3_spectrum_integrator_if.slave bus,
    output logic [DROP_W-1:0]     dropped
);
    localparam int ACC_W   = WIDTH + AVG_LOG2;
    localparam int FRAME_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [FRAME_W-1:0]   LAST_FRAME = FRAME_W'((1 << AVG_LOG2) - 1);
    localparam logic [BINS_LOG2-1:0] LAST_BIN   = '1;

    state_t               state, state_nxt;
    logic [BINS_LOG2-1:0] bin_cnt, bin_nxt;
    logic [FRAME_W-1:0]   frame_cnt, frame_nxt;

    logic                 accept, accept_first, drop_evt, start_dump;
    logic [BINS_LOG2-1:0] accept_bin;
    logic                 issue, load_out;
    logic                 ram_re;
    logic [BINS_LOG2-1:0] ram_raddr;
    logic [ACC_W-1:0]     ram_rdata, ram_wdata;

    // Second RMW stage: the word whose accumulator read is in flight.
    logic                 s1_valid, s1_first;
    logic [BINS_LOG2-1:0] s1_bin;
    logic [WIDTH-1:0]     s1_data;

    // Dump read side: next bin to read, and the beat held in the RAM output.
    logic [BINS_LOG2-1:0] rd_bin, r_bin;
    logic                 rd_done, r_valid;

    assign ram_wdata = s1_first ? ACC_W'(s1_data) : ram_rdata + ACC_W'(s1_data);

    pr3_acc_ram #(.ADDR_W(BINS_LOG2), .DATA_W(ACC_W)) u_acc_ram (
        .clk   (clk20),
        .we    (s1_valid),
        .waddr (s1_bin),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk20 or negedge reset) begin
        if (!reset) state <= WAIT_SOP;
        else        state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        bin_nxt      = bin_cnt;
        frame_nxt    = frame_cnt;
        accept       = 1'b0;
        accept_first = 1'b0;
        accept_bin   = bin_cnt;
        drop_evt     = 1'b0;
        start_dump   = 1'b0;
        load_out     = 1'b0;
        issue        = 1'b0;
        ram_re       = 1'b0;
        ram_raddr    = bin_cnt;

        unique case (state)
            WAIT_SOP: begin
                if (bus.sink_valid && bus.sink_sop) begin
                    accept       = 1'b1;
                    accept_first = 1'b1;
                    accept_bin   = '0;
                    bin_nxt      = BINS_LOG2'(1);
                    frame_nxt    = '0;
                    state_nxt    = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.sink_valid) begin
                    if (bus.sink_sop && bin_cnt != '0) begin
                        // Early sop: restart the integration on this word.
                        drop_evt     = 1'b1;
                        accept       = 1'b1;
                        accept_first = 1'b1;
                        accept_bin   = '0;
                        bin_nxt      = BINS_LOG2'(1);
                        frame_nxt    = '0;
                    end else if (!bus.sink_sop && bin_cnt == '0) begin
                        drop_evt  = 1'b1;
                        state_nxt = WAIT_SOP;
                    end else begin
                        accept       = 1'b1;
                        accept_first = (frame_cnt == '0);
                        bin_nxt      = bin_cnt + 1'b1;
                        if (bin_cnt == LAST_BIN) begin
                            frame_nxt = frame_cnt + 1'b1;
                            if (frame_cnt == LAST_FRAME) begin
                                state_nxt  = DUMP;
                                start_dump = 1'b1;
                            end
                        end
                    end
                end
                ram_re    = accept;
                ram_raddr = accept_bin;
            end
            DUMP: begin
                drop_evt = bus.sink_valid && bus.sink_sop;
                // The RAM output only advances when its beat can move on.
                load_out  = r_valid && (!bus.source_valid || bus.source_ready);
                issue     = !rd_done && (!r_valid || load_out);
                ram_re    = issue;
                ram_raddr = rd_bin;
                if (bus.source_valid && bus.source_ready && bus.source_eop)
                    state_nxt = WAIT_SOP;
            end
            default: state_nxt = WAIT_SOP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk20 or negedge reset) begin
        if (!reset) begin
            bin_cnt          <= '0;
            frame_cnt        <= '0;
            s1_valid         <= 1'b0;
            s1_first         <= 1'b0;
            s1_bin           <= '0;
            s1_data          <= '0;
            rd_bin           <= '0;
            rd_done          <= 1'b0;
            r_valid          <= 1'b0;
            r_bin            <= '0;
            bus.source_valid <= 1'b0;
            bus.source_sop   <= 1'b0;
            bus.source_eop   <= 1'b0;
            bus.source_data  <= '0;
            dropped          <= '0;
        end else begin
            bin_cnt   <= bin_nxt;
            frame_cnt <= frame_nxt;

            s1_valid <= accept;
            if (accept) begin
                s1_first <= accept_first;
                s1_bin   <= accept_bin;
                s1_data  <= bus.sink_data;
            end

            if (start_dump) begin
                rd_bin  <= '0;
                rd_done <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                if (issue) begin
                    r_bin <= rd_bin;
                    if (rd_bin == LAST_BIN) rd_done <= 1'b1;
                    else                    rd_bin  <= rd_bin + 1'b1;
                end
                if (issue)         r_valid <= 1'b1;
                else if (load_out) r_valid <= 1'b0;
            end

            if (load_out) begin
                bus.source_valid <= 1'b1;
                bus.source_sop   <= (r_bin == '0);
                bus.source_eop   <= (r_bin == LAST_BIN);
                bus.source_data  <= WIDTH'(avg_trunc(64'(ram_rdata), AVG_LOG2));
            end else if (bus.source_ready) begin
                bus.source_valid <= 1'b0;
            end

            if (drop_evt && dropped != '1) dropped <= dropped + 1'b1;
        end
    end
endmodule

// File: tb/tb_pr3_spectrum_integrator.sv
// Randomised scenario bench for pr3_spectrum_integrator against a frame-level
// model of the integration, resync and dump rules.
module tb_pr3_spectrum_integrator;
    import pr3_pkg::*;

    localparam int W  = 32;
    localparam int BL = 3;
    localparam int AL = 2;
    localparam int NB = 1 << BL;
    localparam int NF = 1 << AL;

    typedef enum int {M_IDLE, M_COLLECT, M_BUSY} mmode_t;
    typedef struct {
        logic [W-1:0] data;
        bit           sop;
        bit           eop;
    } beat_t;

    logic clk20 = 1'b0;
    logic reset = 1'b0;
    logic [DROP_W-1:0] dropped;
    always #5 clk20 = ~clk20;

    pr3_spectrum_integrator_if #(.WIDTH(W)) bus();

    pr3_spectrum_integrator #(.WIDTH(W), .BINS_LOG2(BL), .AVG_LOG2(AL)) dut (
        .clk20   (clk20),
        .reset   (reset),
        .bus     (bus),
        .dropped (dropped)
    );

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;

    mmode_t       m_mode = M_IDLE;
    int           m_bin, m_frame;
    int           m_drops = 0;
    int           drops_seen = 0;
    logic [W-1:0] m_frm [NF][NB];
    beat_t        exp_q[$];
    logic [W-1:0] log_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        log_q.delete();
        m_mode     = M_IDLE;
        m_drops    = 0;
        drops_seen = 0;
    endtask

    // Frame-level model: collect NF whole frames, then queue their averages.
    task automatic model_push(input bit sop, input logic [W-1:0] d);
        beat_t e;
        if (m_mode == M_BUSY) begin
            if (sop) m_drops++;
            return;
        end
        if (m_mode == M_IDLE) begin
            if (!sop) return;
            m_mode = M_COLLECT; m_bin = 0; m_frame = 0;
        end else if (sop && m_bin != 0) begin
            m_drops++; m_bin = 0; m_frame = 0;
        end else if (!sop && m_bin == 0) begin
            m_drops++; m_mode = M_IDLE;
            return;
        end
        m_frm[m_frame][m_bin] = d;
        m_bin++;
        if (m_bin == NB) begin
            m_bin = 0;
            m_frame++;
            if (m_frame == NF) begin
                for (int b = 0; b < NB; b++) begin
                    longint s = 0;
                    for (int f = 0; f < NF; f++) s += m_frm[f][b];
                    e.data = W'(s / NF);
                    e.sop  = (b == 0);
                    e.eop  = (b == NB - 1);
                    exp_q.push_back(e);
                end
                m_mode = M_BUSY;
            end
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
        @(posedge clk20); #1;
        bus.sink_valid = v;
        bus.sink_sop   = s;
        bus.sink_data  = d;
        if (v) model_push(s, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    // kind 0: 100+bin; 1: random; 2: random with bin0 forced. first_bin lets a frame start mid-way.
    task automatic send_frame(input int kind, input logic [W-1:0] bin0, input bit gaps,
                              input int first_bin = 0, input int last_bin = NB - 1,
                              input bit use_sop = 1'b1);
        logic [W-1:0] d;
        for (int b = first_bin; b <= last_bin; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if (kind == 0)                 d = W'(100 + b);
            else if (kind == 2 && b == 0)  d = bin0;
            else                           d = $urandom();
            drive(1'b1, use_sop && (b == 0), d);
        end
    endtask

    task automatic do_reset();
        @(posedge clk20); #1;
        reset = 1'b0;
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        #1;
        check("reset_valid", 64'(bus.source_valid), 64'd0);
        check("reset_dropped", 64'(dropped), 64'd0);
        model_reset();
        repeat (2) @(posedge clk20);
        #1 reset = 1'b1;
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (log_q.size() < n && c < 300) begin
            @(posedge clk20);
            c++;
        end
        check("beat_count", 64'(log_q.size()), 64'(n));
        idle(4);
        check("exp_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bus.source_ready = 1'b1;
        forever begin
            @(posedge clk20); #1;
            case (rdy_mode)
                0:       bus.source_ready = 1'b1;
                1:       bus.source_ready = 1'($urandom_range(0, 1));
                default: bus.source_ready = 1'b0;
            endcase
        end
    end

    // Compare process: dropped every cycle, stall stability, and each transferred beat.
    initial begin
        logic [63:0] cur, prev_beat;
        bit          prev_stall;
        beat_t       e;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk20);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                check("dropped", 64'(dropped), 64'(drops_seen));
                drops_seen = m_drops;
                cur = {29'd0, bus.source_valid, bus.source_sop, bus.source_eop, bus.source_data};
                if (prev_stall) check("stall_hold", cur, prev_beat);
                if (bus.source_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_beat", 64'(bus.source_valid), 64'd0);
                    end else if (bus.source_ready) begin
                        e = exp_q.pop_front();
                        check("beat_data", 64'(bus.source_data), 64'(e.data));
                        check("beat_sop", 64'(bus.source_sop), 64'(e.sop));
                        check("beat_eop", 64'(bus.source_eop), 64'(e.eop));
                        log_q.push_back(bus.source_data);
                        if (bus.source_eop && m_mode == M_BUSY) m_mode = M_IDLE;
                    end
                end
                prev_stall = bus.source_valid && !bus.source_ready;
                prev_beat  = cur;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_data  = '0;

        // Ramp data: averages equal the inputs.
        do_reset();
        for (int f = 0; f < NF; f++) send_frame(0, '0, 1'b0);
        wait_beats(NB);
        for (int k = 0; k < NB; k++) check("ramp_value", 64'(log_q[k]), 64'(100 + k));
        check("ramp_dropped", 64'(dropped), 64'd0);

        // Truncation: bin 0 sum 5 averages to 1.
        do_reset();
        send_frame(2, 32'd1, 1'b0);
        send_frame(2, 32'd1, 1'b0);
        send_frame(2, 32'd1, 1'b0);
        send_frame(2, 32'd2, 1'b0);
        wait_beats(NB);
        check("trunc_bin0", 64'(log_q[0]), 64'd1);

        // Random data with gaps and 50% backpressure.
        do_reset();
        rdy_mode = 1;
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < NF; f++) send_frame(1, '0, 1'b1);
            wait_beats(NB * (r + 1));
        end
        rdy_mode = 0;

        // Early sop at bin 5 of frame 1 restarts the integration.
        do_reset();
        send_frame(1, '0, 1'b0);
        send_frame(1, '0, 1'b0, 0, 4);
        send_frame(1, '0, 1'b0);
        for (int f = 1; f < NF; f++) send_frame(1, '0, 1'b0);
        wait_beats(NB);
        check("resync_dropped", 64'(dropped), 64'd1);

        // Expected bin 0 without sop: drop and wait for the next sop.
        do_reset();
        send_frame(1, '0, 1'b0);
        send_frame(1, '0, 1'b0, 0, NB - 1, 1'b0);
        idle(2);
        check("nosop_dropped", 64'(dropped), 64'd1);
        for (int f = 0; f < NF; f++) send_frame(1, '0, 1'b1);
        wait_beats(NB);
        check("nosop_dropped_after", 64'(dropped), 64'd1);

        // Two frames arrive while the dump is held off.
        do_reset();
        rdy_mode = 2;
        for (int f = 0; f < NF; f++) send_frame(1, '0, 1'b0);
        send_frame(1, '0, 1'b0);
        send_frame(1, '0, 1'b0);
        idle(3);
        check("busy_dropped", 64'(dropped), 64'd2);
        check("busy_no_beats", 64'(log_q.size()), 64'd0);
        rdy_mode = 0;
        wait_beats(NB);
        for (int f = 0; f < NF; f++) send_frame(1, '0, 1'b0);
        wait_beats(2 * NB);
        check("busy_dropped_after", 64'(dropped), 64'd2);

        // Reset in the middle of a dump discards everything.
        do_reset();
        for (int f = 0; f < NF; f++) send_frame(1, '0, 1'b0);
        begin
            int c = 0;
            while (log_q.size() < 3 && c < 100) begin
                @(posedge clk20);
                c++;
            end
            check("middump_reached", 64'(log_q.size() >= 3), 64'd1);
        end
        do_reset();
        for (int f = 0; f < NF - 1; f++) send_frame(1, '0, 1'b0);
        idle(20);
        check("postreset_silent", 64'(log_q.size()), 64'd0);
        send_frame(1, '0, 1'b0);
        wait_beats(NB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
